rv_hazard_ctrl: RTL and testbench
=================================

Name: rv_hazard_ctrl

Overview:
- Parametrised pipeline hazard/control unit for the 5-stage RV core; next generation of the non-staged control path.
- Generalised in four ways:
  - N register-read ports and N forwarding sources.
  - Multi-cycle load-use stall.
  - Configurable post-reset flush window.
  - Sticky invalid-instruction trap with explicit clear, plus a stall-cycle performance counter.
- Sits beside the pipeline. Drives stall/flush of fetch, decode and exec, and the exec-stage operand bypass selects.

Parameters:
- NUM_RS, 2, register read ports per instruction (1..3).
- NUM_FWD, 3, forwarding sources; index 0 = youngest (memory), then write, write-back, ...
- REG_AW, 5, register address width.
- LOAD_LAT, 0, extra cycles beyond one before a load result can be forwarded (0..7).
- RESET_FLUSH, 2, cycles both flushes stay high after reset deasserts (1..15).
- CNT_W, 16, stall counter width.
- Derived: BPW = $clog2(NUM_FWD+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_fetch_bus_ack  in  1  fetch bus returned data this cycle.
- i_decode_rs  in  NUM_RS*REG_AW  decode-stage source regs; port k at [k*REG_AW +: REG_AW].
- i_decode_inv_instr  in  1  decode reports an illegal instruction.
- i_exec_rs  in  NUM_RS*REG_AW  exec-stage source regs.
- i_exec_rd  in  REG_AW  exec-stage destination.
- i_exec_is_load  in  1  exec instruction writes rd from memory/TCM.
- i_exec_pc_sel  in  1  taken branch/jump resolved in exec.
- i_fwd_rd  in  NUM_FWD*REG_AW  destination of each forwarding source.
- i_fwd_we  in  NUM_FWD  register-write enable of each source.
- i_trap_clear  in  1  one-cycle pulse releasing the invalid-instruction trap.
- o_exec_bp  out  NUM_RS*BPW  per-port bypass select: 0 = regfile, j+1 = source j.
- o_fetch_stall  out  1  hold PC/fetch register.
- o_decode_stall  out  1  hold decode register.
- o_decode_flush  out  1  bubble into decode.
- o_exec_flush  out  1  bubble into exec.
- o_inv_trap  out  1  sticky trap flag.
- o_stall_cnt  out  CNT_W  saturating count of fetch-stall cycles.

Behaviour:
- **Reset values** (i_reset high; takes effect at the next edge):
  - o_decode_flush = o_exec_flush = 1.
  - o_fetch_stall = o_decode_stall = 0.
  - o_inv_trap = 0, o_stall_cnt = 0, o_exec_bp = 0.
  - Load counter = 0. Flush counter loaded with RESET_FLUSH.
- **Reset window:** after reset falls, both flushes stay 1 for exactly RESET_FLUSH cycles (counter decrements to 0). Stalls are gated to 0 while i_reset is high or the flush counter is nonzero.
- **Forwarding** (combinational, per port k):
  - Select the lowest j with i_fwd_we[j], i_exec_rs[k] != 0 and i_exec_rs[k] == i_fwd_rd[j]; output j+1.
  - If no j qualifies, output 0.
  - x0 never forwards.
- **Load-use hit:** i_exec_is_load, i_exec_rd != 0, i_exec_rd equal to any nonzero i_decode_rs[k], and i_exec_pc_sel = 0.
  - A hit stalls the current cycle and loads the load counter with LOAD_LAT.
  - While the counter is nonzero it decrements each cycle and the stall persists. Total stall = 1 + LOAD_LAT cycles.
  - i_exec_pc_sel clears the counter and suppresses the hit (wrong-path decode).
- **Stall cause set** (w_stall) = load-use active | !i_fetch_bus_ack | o_inv_trap.
- **Output equations:**
  - o_fetch_stall = o_decode_stall = w_stall.
  - o_exec_flush = i_exec_pc_sel | w_stall | reset window.
  - o_decode_flush = i_exec_pc_sel | o_inv_trap | reset window.
- **Trap:**
  - Set at an edge when i_decode_inv_instr & !o_decode_flush.
  - Cleared by i_trap_clear; clear wins over a same-cycle set.
  - While set, decode is flushed and fetch is held.
- **Stall counter:**
  - Increments each cycle o_fetch_stall = 1.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- **Reset mid-stall:** load counter and trap are discarded immediately; outputs take reset values at the next edge.

Test Plan:
- Reset then release, RESET_FLUSH=2: flushes high during reset plus exactly 2 cycles after; stalls 0 throughout; o_stall_cnt=0.
- Forwarding: exec rs1=5; fwd0 rd=5 we=1; fwd1 rd=5 we=1 -> bp rs1=1. Drop fwd0 we -> 2. rs1=0 with matching fwd rd=0 -> 0.
- Load-use, LOAD_LAT=2: exec load rd=7, decode rs2=7 -> fetch/decode stall and exec_flush for exactly 3 cycles, then release; o_stall_cnt +3.
- Load-use with same-cycle i_exec_pc_sel=1 -> no stall, decode_flush=exec_flush=1, counter stays 0.
- i_decode_inv_instr pulse outside flush -> o_inv_trap=1 next cycle, fetch stall + decode flush held 20 cycles; i_trap_clear -> trap 0 next cycle. Inv pulse during reset window -> trap stays 0.
- i_fetch_bus_ack low for 2^CNT_W+5 cycles (CNT_W=4) -> o_stall_cnt saturates at 15, never wraps.

Source files
------------

// File: rtl/rv_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and rv_hazard_ctrl.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface rv_hazard_ctrl_if #(
    parameter int unsigned NUM_RS  = 2,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned BPW = $clog2(NUM_FWD + 1);

    logic                       i_fetch_bus_ack;
    logic [NUM_RS*REG_AW-1:0]   i_decode_rs;
    logic                       i_decode_inv_instr;
    logic [NUM_RS*REG_AW-1:0]   i_exec_rs;
    logic [REG_AW-1:0]          i_exec_rd;
    logic                       i_exec_is_load;
    logic                       i_exec_pc_sel;
    logic [NUM_FWD*REG_AW-1:0]  i_fwd_rd;
    logic [NUM_FWD-1:0]         i_fwd_we;
    logic                       i_trap_clear;

    logic [NUM_RS*BPW-1:0]      o_exec_bp;
    logic                       o_fetch_stall;
    logic                       o_decode_stall;
    logic                       o_decode_flush;
    logic                       o_exec_flush;
    logic                       o_inv_trap;
    logic [CNT_W-1:0]           o_stall_cnt;

    modport master (
        output i_fetch_bus_ack, i_decode_rs, i_decode_inv_instr, i_exec_rs, i_exec_rd,
               i_exec_is_load, i_exec_pc_sel, i_fwd_rd, i_fwd_we, i_trap_clear,
        input  o_exec_bp, o_fetch_stall, o_decode_stall, o_decode_flush, o_exec_flush,
               o_inv_trap, o_stall_cnt
    );

    modport slave (
        input  i_fetch_bus_ack, i_decode_rs, i_decode_inv_instr, i_exec_rs, i_exec_rd,
               i_exec_is_load, i_exec_pc_sel, i_fwd_rd, i_fwd_we, i_trap_clear,
        output o_exec_bp, o_fetch_stall, o_decode_stall, o_decode_flush, o_exec_flush,
               o_inv_trap, o_stall_cnt
    );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard/control unit: operand bypass selects, multi-cycle load-use stall,
// post-reset flush window, sticky invalid-instruction trap and a stall-cycle counter.
module rv_hazard_ctrl #(
    parameter int unsigned NUM_RS      = 2,
    parameter int unsigned NUM_FWD     = 3,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LOAD_LAT    = 0,
    parameter int unsigned RESET_FLUSH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rv_hazard_ctrl_if.slave bus
);
    localparam int unsigned BPW = $clog2(NUM_FWD + 1);

    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic [2:0]            ld_cnt_q, ld_cnt_d;
    logic                  trap_q, trap_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic                  reset_win;
    logic                  dec_match;
    logic                  ld_hit;
    logic                  ld_active;
    logic                  stall;
    logic                  decode_flush;
    logic [NUM_RS*BPW-1:0] exec_bp;

    // Descending scan so the lowest (youngest) matching source wins.
    always_comb begin
        exec_bp = '0;
        if (!i_reset) begin
            for (int k = 0; k < int'(NUM_RS); k++) begin
                for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
                    if (bus.i_fwd_we[j] &&
                        (bus.i_exec_rs[k*REG_AW +: REG_AW] != '0) &&
                        (bus.i_exec_rs[k*REG_AW +: REG_AW] == bus.i_fwd_rd[j*REG_AW +: REG_AW])) begin
                        exec_bp[k*BPW +: BPW] = BPW'(j + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        dec_match = 1'b0;
        for (int k = 0; k < int'(NUM_RS); k++) begin
            if ((bus.i_decode_rs[k*REG_AW +: REG_AW] != '0) &&
                (bus.i_decode_rs[k*REG_AW +: REG_AW] == bus.i_exec_rd)) begin
                dec_match = 1'b1;
            end
        end
    end

    always_comb begin
        ld_hit       = bus.i_exec_is_load & (bus.i_exec_rd != '0) & dec_match &
                       ~bus.i_exec_pc_sel;
        reset_win    = i_reset | (flush_cnt_q != '0);
        ld_active    = ld_hit | (ld_cnt_q != '0);
        stall        = ~reset_win & (ld_active | ~bus.i_fetch_bus_ack | trap_q);
        decode_flush = bus.i_exec_pc_sel | trap_q | reset_win;
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
        end

        // A taken branch means the decode instruction was wrong-path: drop the stall.
        ld_cnt_d = ld_cnt_q;
        if (bus.i_exec_pc_sel) begin
            ld_cnt_d = '0;
        end else if (ld_hit) begin
            ld_cnt_d = 3'(LOAD_LAT);
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - 3'd1;
        end

        trap_d = trap_q;
        if (bus.i_trap_clear) begin
            trap_d = 1'b0;
        end else if (bus.i_decode_inv_instr && !decode_flush) begin
            trap_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            flush_cnt_q <= 4'(RESET_FLUSH);
            ld_cnt_q    <= '0;
            trap_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            trap_q      <= trap_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.o_exec_bp      = exec_bp;
    assign bus.o_fetch_stall  = stall;
    assign bus.o_decode_stall = stall;
    assign bus.o_decode_flush = decode_flush;
    assign bus.o_exec_flush   = bus.i_exec_pc_sel | stall | reset_win;
    assign bus.o_inv_trap     = trap_q;
    assign bus.o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Randomised bench for rv_hazard_ctrl against a cycle-level behavioural model,
// preceded by directed scenarios with hand-computed expectations.
module tb_rv_hazard_ctrl;
    localparam int NRS  = 2;
    localparam int NFWD = 3;
    localparam int AW   = 5;
    localparam int LL   = 2;
    localparam int RF   = 2;
    localparam int CW   = 4;
    localparam int BPW  = $clog2(NFWD + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rv_hazard_ctrl_if #(.NUM_RS(NRS), .NUM_FWD(NFWD), .REG_AW(AW), .CNT_W(CW)) bus ();

    rv_hazard_ctrl #(
        .NUM_RS(NRS), .NUM_FWD(NFWD), .REG_AW(AW),
        .LOAD_LAT(LL), .RESET_FLUSH(RF), .CNT_W(CW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    // Model state: remaining flush cycles, remaining extra load-stall cycles, trap, counter.
    bit m_valid = 1'b0;
    int m_flush = 0;
    int m_ld    = 0;
    bit m_trap  = 1'b0;
    int m_cnt   = 0;

    function automatic int rs_of(input logic [NRS*AW-1:0] v, input int k);
        return int'(v[k*AW +: AW]);
    endfunction

    function automatic bit m_win();
        return rst || (m_flush > 0);
    endfunction

    function automatic bit m_hit();
        bit any = 1'b0;
        for (int k = 0; k < NRS; k++)
            if (rs_of(bus.i_decode_rs, k) != 0 && rs_of(bus.i_decode_rs, k) == int'(bus.i_exec_rd))
                any = 1'b1;
        return bus.i_exec_is_load && (bus.i_exec_rd != 0) && any && !bus.i_exec_pc_sel;
    endfunction

    function automatic bit m_stall();
        if (m_win()) return 1'b0;
        return m_hit() || (m_ld > 0) || !bus.i_fetch_bus_ack || m_trap;
    endfunction

    function automatic bit m_dflush();
        return bus.i_exec_pc_sel || m_trap || m_win();
    endfunction

    function automatic bit m_eflush();
        return bus.i_exec_pc_sel || m_stall() || m_win();
    endfunction

    function automatic logic [NRS*BPW-1:0] m_bp();
        logic [NRS*BPW-1:0] r = '0;
        if (rst) return r;
        for (int k = 0; k < NRS; k++) begin
            int rs = rs_of(bus.i_exec_rs, k);
            for (int j = 0; j < NFWD; j++) begin
                if (rs != 0 && bus.i_fwd_we[j] && rs == int'(bus.i_fwd_rd[j*AW +: AW])) begin
                    r[k*BPW +: BPW] = BPW'(j + 1);
                    break;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_flush <= RF;
            m_ld    <= 0;
            m_trap  <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_flush <= (m_flush > 0) ? m_flush - 1 : 0;
            if (bus.i_exec_pc_sel)  m_ld <= 0;
            else if (m_hit())       m_ld <= LL;
            else if (m_ld > 0)      m_ld <= m_ld - 1;
            if (bus.i_trap_clear)                           m_trap <= 1'b0;
            else if (bus.i_decode_inv_instr && !m_dflush()) m_trap <= 1'b1;
            if (m_stall()) m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_bp",     32'(bus.o_exec_bp),      32'(m_bp()));
            cmp("model_fstall", 32'(bus.o_fetch_stall),  32'(m_stall()));
            cmp("model_dstall", 32'(bus.o_decode_stall), 32'(m_stall()));
            cmp("model_dflush", 32'(bus.o_decode_flush), 32'(m_dflush()));
            cmp("model_eflush", 32'(bus.o_exec_flush),   32'(m_eflush()));
            cmp("model_trap",   32'(bus.o_inv_trap),     32'(m_trap));
            cmp("model_cnt",    32'(bus.o_stall_cnt),    32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal checks land after the model compare process at the same negedge.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_fetch_bus_ack    = 1'b1;
        bus.i_decode_rs        = '0;
        bus.i_decode_inv_instr = 1'b0;
        bus.i_exec_rs          = '0;
        bus.i_exec_rd          = '0;
        bus.i_exec_is_load     = 1'b0;
        bus.i_exec_pc_sel      = 1'b0;
        bus.i_fwd_rd           = '0;
        bus.i_fwd_we           = '0;
        bus.i_trap_clear       = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        settle();
        cmp("rst_dflush", 32'(bus.o_decode_flush), 32'd1);
        cmp("rst_eflush", 32'(bus.o_exec_flush),   32'd1);
        cmp("rst_fstall", 32'(bus.o_fetch_stall),  32'd0);
        cmp("rst_cnt",    32'(bus.o_stall_cnt),    32'd0);

        // Reset window: flushes for exactly RF cycles after release.
        step(); rst = 1'b0;
        for (int i = 0; i < RF; i++) begin
            settle();
            cmp("win_dflush", 32'(bus.o_decode_flush), 32'd1);
            cmp("win_fstall", 32'(bus.o_fetch_stall),  32'd0);
            step();
        end
        settle();
        cmp("post_win_dflush", 32'(bus.o_decode_flush), 32'd0);
        cmp("post_win_eflush", 32'(bus.o_exec_flush),   32'd0);
        step();

        // Forwarding priority.
        bus.i_exec_rs[0 +: AW] = 5'd5;
        bus.i_fwd_rd = {5'd0, 5'd5, 5'd5};
        bus.i_fwd_we = 3'b011;
        settle(); cmp("fwd_src0", 32'(bus.o_exec_bp[0 +: BPW]), 32'd1);
        step();
        bus.i_fwd_we = 3'b010;
        settle(); cmp("fwd_src1", 32'(bus.o_exec_bp[0 +: BPW]), 32'd2);
        step();
        bus.i_exec_rs[0 +: AW] = 5'd0;
        bus.i_fwd_rd = '0;
        bus.i_fwd_we = 3'b111;
        settle(); cmp("fwd_x0", 32'(bus.o_exec_bp), 32'd0);
        step();
        idle_inputs();

        // Load-use with LL=2: three stall cycles.
        bus.i_exec_is_load = 1'b1;
        bus.i_exec_rd = 5'd7;
        bus.i_decode_rs[AW +: AW] = 5'd7;
        for (int i = 0; i < 3; i++) begin
            settle();
            cmp("lu_fstall", 32'(bus.o_fetch_stall), 32'd1);
            cmp("lu_eflush", 32'(bus.o_exec_flush),  32'd1);
            step();
            idle_inputs();
        end
        settle();
        cmp("lu_release", 32'(bus.o_fetch_stall), 32'd0);
        cmp("lu_cnt",     32'(bus.o_stall_cnt),   32'd3);
        step();

        // Load-use squashed by a taken branch.
        bus.i_exec_is_load = 1'b1;
        bus.i_exec_rd = 5'd7;
        bus.i_decode_rs[AW +: AW] = 5'd7;
        bus.i_exec_pc_sel = 1'b1;
        settle();
        cmp("br_fstall", 32'(bus.o_fetch_stall),  32'd0);
        cmp("br_dflush", 32'(bus.o_decode_flush), 32'd1);
        cmp("br_eflush", 32'(bus.o_exec_flush),   32'd1);
        step();
        idle_inputs();
        settle();
        cmp("br_no_stall", 32'(bus.o_fetch_stall), 32'd0);
        step();

        // Sticky trap, then clear.
        bus.i_decode_inv_instr = 1'b1;
        step();
        bus.i_decode_inv_instr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            cmp("trap_set",    32'(bus.o_inv_trap),     32'd1);
            cmp("trap_fstall", 32'(bus.o_fetch_stall),  32'd1);
            cmp("trap_dflush", 32'(bus.o_decode_flush), 32'd1);
            step();
        end
        bus.i_trap_clear = 1'b1;
        step();
        bus.i_trap_clear = 1'b0;
        settle(); cmp("trap_clear", 32'(bus.o_inv_trap), 32'd0);
        step();

        // Invalid instruction inside the reset window must not trap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_decode_inv_instr = 1'b1;
        step();
        bus.i_decode_inv_instr = 1'b0;
        settle(); cmp("win_no_trap", 32'(bus.o_inv_trap), 32'd0);
        step();

        // Counter saturation.
        bus.i_fetch_bus_ack = 1'b0;
        repeat ((1 << CW) + 5) step();
        settle(); cmp("cnt_sat", 32'(bus.o_stall_cnt), 32'(CMAX));
        step();
        idle_inputs();

        // Randomised traffic over a small register range so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            rst                    = ($urandom_range(0, 99) == 0);
            bus.i_fetch_bus_ack    = ($urandom_range(0, 3) != 0);
            bus.i_decode_inv_instr = ($urandom_range(0, 19) == 0);
            bus.i_trap_clear       = ($urandom_range(0, 15) == 0);
            bus.i_exec_pc_sel      = ($urandom_range(0, 9) == 0);
            bus.i_exec_is_load     = ($urandom_range(0, 2) == 0);
            bus.i_exec_rd          = AW'($urandom_range(0, 7));
            bus.i_fwd_we           = NFWD'($urandom_range(0, 7));
            for (int k = 0; k < NRS; k++) begin
                bus.i_decode_rs[k*AW +: AW] = AW'($urandom_range(0, 7));
                bus.i_exec_rs[k*AW +: AW]   = AW'($urandom_range(0, 7));
            end
            for (int j = 0; j < NFWD; j++)
                bus.i_fwd_rd[j*AW +: AW] = AW'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
